// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive-side VGA timing recovery. Rebuilds pixel_x/pixel_y from active-low
// hsync/vsync sampled on a pixel-rate strobe, checks every sync edge against
// the nominal timing and declares lock after LOCK_FRAMES clean frames.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SEARCH   | waiting for a vsync fall to align the counters; errors muted
// ACQUIRE  | aligned, counting clean vsync-to-vsync frames toward lock
// LOCKED   | stream trusted: locked_o high, frame_start_o enabled
module vga_sync_decoder #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned HSYNC_START = 656,
    parameter int unsigned HSYNC_END   = 752,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned VSYNC_START = 490,
    parameter int unsigned VSYNC_END   = 492,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned X_POS_W     = 10,
    parameter int unsigned Y_POS_W     = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               px_en_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [X_POS_W-1:0] pixel_x_o,
    output logic [Y_POS_W-1:0] pixel_y_o,
    output logic               visible_range_o,
    output logic               locked_o,
    output logic               frame_start_o,
    output logic               h_err_o,
    output logic               v_err_o
);

    localparam logic [X_POS_W-1:0] X_LAST   = X_POS_W'(H_TOTAL - 1);
    localparam logic [X_POS_W-1:0] X_HS_BEG = X_POS_W'(HSYNC_START);
    localparam logic [X_POS_W-1:0] X_HS_END = X_POS_W'(HSYNC_END);
    localparam logic [X_POS_W-1:0] X_VIS    = X_POS_W'(H_RES);
    localparam logic [Y_POS_W-1:0] Y_LAST   = Y_POS_W'(V_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] Y_VS_BEG = Y_POS_W'(VSYNC_START);
    localparam logic [Y_POS_W-1:0] Y_VS_END = Y_POS_W'(VSYNC_END);
    localparam logic [Y_POS_W-1:0] Y_VIS    = Y_POS_W'(V_RES);
    localparam logic [3:0]         GOOD_TARGET = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         good_q, good_d, good_inc;

    logic               hs_q, vs_q;
    logic               hs_fall, hs_rise, vs_fall, vs_rise;

    logic [X_POS_W-1:0] x_q, x_d, x_n;
    logic [Y_POS_W-1:0] y_q, y_d, y_n;
    logic               x_wrap;

    logic               xn_at_hs_beg, xn_at_hs_end, xn_at_zero;
    logic               yn_at_vs_beg, yn_at_vs_end;
    logic               h_err, v_err, any_err;

    logic               locked, err_active;
    logic               h_err_d, v_err_d, frame_start_d;
    logic               h_err_q, v_err_q, frame_start_q;

    // Sync edges on this beat; everything downstream is qualified by the strobe.
    always_comb begin
        hs_fall = px_en_i &  hs_q & ~hsync_i;
        hs_rise = px_en_i & ~hs_q &  hsync_i;
        vs_fall = px_en_i &  vs_q & ~vsync_i;
        vs_rise = px_en_i & ~vs_q &  vsync_i;
    end

    // Previous sync levels; idle-high so a stream starting low shows a fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (px_en_i) begin
            hs_q <= hsync_i;
            vs_q <= vsync_i;
        end
    end

    // Position the free-running raster would reach on this beat.
    always_comb begin
        x_wrap = (x_q == X_LAST);
        x_n    = x_wrap ? '0 : x_q + X_POS_W'(1);
        y_n    = y_q;
        if (x_wrap) begin
            y_n = (y_q == Y_LAST) ? '0 : y_q + Y_POS_W'(1);
        end
    end

    // Counter update: vsync fall realigns both axes, hsync fall realigns x only.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (px_en_i) begin
            if (vs_fall) begin
                x_d = '0;
                y_d = Y_VS_BEG;
            end else if (hs_fall) begin
                x_d = X_HS_BEG;
                y_d = y_n;
            end else begin
                x_d = x_n;
                y_d = y_n;
            end
        end
    end

    // Coordinate counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Edge-vs-prediction checks: an edge where none is due, or a due edge missing.
    always_comb begin
        xn_at_hs_beg = (x_n == X_HS_BEG);
        xn_at_hs_end = (x_n == X_HS_END);
        xn_at_zero   = (x_n == '0);
        yn_at_vs_beg = (y_n == Y_VS_BEG);
        yn_at_vs_end = (y_n == Y_VS_END);

        h_err = px_en_i & ((hs_fall & ~xn_at_hs_beg) | (~hs_fall & xn_at_hs_beg) |
                           (hs_rise & ~xn_at_hs_end) | (~hs_rise & xn_at_hs_end));

        // Vertical edges are only legal at line start; elsewhere a vsync fall is itself wrong.
        if (xn_at_zero) begin
            v_err = px_en_i & ((vs_fall & ~yn_at_vs_beg) | (~vs_fall & yn_at_vs_beg) |
                               (vs_rise & ~yn_at_vs_end) | (~vs_rise & yn_at_vs_end));
        end else begin
            v_err = vs_fall;
        end

        any_err = h_err | v_err;
    end

    // Lock FSM: state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Lock FSM: next state. An error on a vsync-fall beat beats the count increment.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        good_inc = good_q + 4'd1;
        unique case (state_q)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (any_err) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end else if (vs_fall) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_TARGET) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (any_err) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // Lock FSM: outputs. Errors are muted in SEARCH since the counters are not yet aligned.
    always_comb begin
        locked        = (state_q == ST_LOCKED);
        err_active    = (state_q != ST_SEARCH);
        h_err_d       = h_err & err_active;
        v_err_d       = v_err & err_active;
        frame_start_d = px_en_i & locked & (x_d == '0) & (y_d == '0);
    end

    // Single-beat status pulses; they drop on any clk without a pixel strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Output drive; the visible window is judged on the registered coordinate.
    always_comb begin
        pixel_x_o       = x_q;
        pixel_y_o       = y_q;
        locked_o        = locked;
        visible_range_o = locked & (x_q < X_VIS) & (y_q < Y_VIS);
        frame_start_o   = frame_start_q;
        h_err_o         = h_err_q;
        v_err_o         = v_err_q;
    end

endmodule
